// File: rtl/tt_processor_if.sv
// Tiny Tapeout user-block pin bundle for tt_processor.
// The master drives the enable, instruction and operand; the slave returns the display.
interface tt_processor_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_processor.sv
// 8-bit accumulator processor, one instruction per clock from ui_in.
// Define TT_PROCESSOR_MUL_EN to turn opcode F from CMP into MUL.
module tt_processor (
    input  logic           clk,
    input  logic           rst_n,
    tt_processor_if.slave  bus
);
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_LDR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_DEC  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_F    = 4'hF;

    logic [7:0] acc;
    logic [7:0] rf [4];
    logic       z_f, c_f, n_f;
    logic       disp_sel;

    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm, src;

    assign op  = bus.ui_in[7:4];
    assign rd  = bus.ui_in[3:2];
    assign rs  = bus.ui_in[1:0];
    assign imm = bus.uio_in;
    assign src = rf[rs];

    logic [8:0]  sum_r, sum_i, diff;
`ifdef TT_PROCESSOR_MUL_EN
    logic [15:0] prod;
    assign prod = acc * src;
`endif

    assign sum_r = {1'b0, acc} + {1'b0, src};
    assign sum_i = {1'b0, acc} + {1'b0, imm};
    assign diff  = {1'b0, acc} - {1'b0, src};

    // res feeds Z/N; acc_wr is separate so CMP can set flags only
    logic [7:0] res;
    logic       acc_wr, zn_wr, c_n, rf_wr, disp_wr;

    always_comb begin
        res     = acc;
        acc_wr  = 1'b0;
        zn_wr   = 1'b0;
        c_n     = c_f;
        rf_wr   = 1'b0;
        disp_wr = 1'b0;
        unique case (op)
            OP_NOP:  disp_wr = 1'b1;
            OP_LDI:  begin res = imm; acc_wr = 1'b1; zn_wr = 1'b1; end
            OP_MOV:  rf_wr = 1'b1;
            OP_LDR:  begin res = src; acc_wr = 1'b1; zn_wr = 1'b1; end
            OP_ADD:  begin
                res = sum_r[7:0]; c_n = sum_r[8];
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_SUB:  begin
                res = diff[7:0]; c_n = diff[8];
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_AND:  begin
                res = acc & src; c_n = 1'b0;
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_OR:   begin
                res = acc | src; c_n = 1'b0;
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_XOR:  begin
                res = acc ^ src; c_n = 1'b0;
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_NOT:  begin
                res = ~acc; c_n = 1'b0;
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_SHL:  begin
                res = {acc[6:0], 1'b0}; c_n = acc[7];
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_SHR:  begin
                res = {1'b0, acc[7:1]}; c_n = acc[0];
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_INC:  begin
                res = acc + 8'd1; c_n = (acc == 8'hFF);
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_DEC:  begin
                res = acc - 8'd1; c_n = (acc == 8'h00);
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_ADDI: begin
                res = sum_i[7:0]; c_n = sum_i[8];
                acc_wr = 1'b1; zn_wr = 1'b1;
            end
            OP_F:    begin
`ifdef TT_PROCESSOR_MUL_EN
                res = prod[7:0]; c_n = |prod[15:8];
                acc_wr = 1'b1; zn_wr = 1'b1;
`else
                res = diff[7:0]; c_n = diff[8];
                zn_wr = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc      <= 8'h00;
            rf[0]    <= 8'h00;
            rf[1]    <= 8'h00;
            rf[2]    <= 8'h00;
            rf[3]    <= 8'h00;
            z_f      <= 1'b0;
            c_f      <= 1'b0;
            n_f      <= 1'b0;
            disp_sel <= 1'b0;
        end else if (bus.ena) begin
            if (acc_wr)  acc      <= res;
            if (rf_wr)   rf[rd]   <= acc;
            if (disp_wr) disp_sel <= bus.ui_in[0];
            if (zn_wr) begin
                z_f <= (res == 8'h00);
                n_f <= res[7];
            end
            c_f <= c_n;
        end
    end

    assign bus.uo_out  = disp_sel ? {5'b0, n_f, c_f, z_f} : acc;
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_processor.sv
// Self-checking bench for tt_processor: directed plan then random
// instruction streams compared against an integer reference model.
module tb_tt_processor;
    logic clk = 1'b0;
    logic rst_n;
    tt_processor_if bus ();

    tt_processor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    int m_acc, m_z, m_c, m_n, m_disp;
    int m_r [4];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic void set_zn(input int v);
        m_z = (v == 0);
        m_n = (v >= 128);
    endfunction

    function automatic void model(input int ui, input int imm,
                                  input bit en, input bit rst);
        int op, rd, rs, a, r, t;
        op = ui / 16;
        rd = (ui / 4) % 4;
        rs = ui % 4;
        a  = m_acc;
        r  = m_r[rs];
        if (rst) begin
            m_acc = 0; m_z = 0; m_c = 0; m_n = 0; m_disp = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
            return;
        end
        if (!en) return;
        case (op)
            0: m_disp = ui % 2;
            1: begin m_acc = imm; set_zn(m_acc); end
            2: m_r[rd] = a;
            3: begin m_acc = r; set_zn(m_acc); end
            4: begin t = a + r; m_acc = t % 256; m_c = t > 255; set_zn(m_acc); end
            5: begin m_acc = (a - r + 256) % 256; m_c = a < r; set_zn(m_acc); end
            6: begin m_acc = a & r; m_c = 0; set_zn(m_acc); end
            7: begin m_acc = a | r; m_c = 0; set_zn(m_acc); end
            8: begin m_acc = a ^ r; m_c = 0; set_zn(m_acc); end
            9: begin m_acc = 255 - a; m_c = 0; set_zn(m_acc); end
            10: begin m_acc = (a * 2) % 256; m_c = a >= 128; set_zn(m_acc); end
            11: begin m_acc = a / 2; m_c = a % 2; set_zn(m_acc); end
            12: begin m_acc = (a + 1) % 256; m_c = a == 255; set_zn(m_acc); end
            13: begin m_acc = (a + 255) % 256; m_c = a == 0; set_zn(m_acc); end
            14: begin t = a + imm; m_acc = t % 256; m_c = t > 255; set_zn(m_acc); end
            default: begin
`ifdef TT_PROCESSOR_MUL_EN
                t = a * r; m_acc = t % 256; m_c = (t / 256) != 0; set_zn(m_acc);
`else
                t = (a - r + 256) % 256; m_c = a < r; set_zn(t);
`endif
            end
        endcase
    endfunction

    function automatic int model_out();
        if (m_disp != 0) return m_n * 4 + m_c * 2 + m_z;
        return m_acc;
    endfunction

    task automatic step(input string tag, input int ui, input int imm,
                        input bit en, input bit rst);
        @(negedge clk);
        bus.ui_in  = 8'(ui);
        bus.uio_in = 8'(imm);
        bus.ena    = en;
        rst_n      = rst;
        @(posedge clk);
        #1;
        model(ui, imm, en, rst);
        check(tag, int'(bus.uo_out), model_out());
    endtask

    task automatic run(input string tag, input int ui, input int imm);
        step(tag, ui, imm, 1'b1, 1'b0);
    endtask

    initial begin
        bus.ena = 1'b1; bus.ui_in = 8'h00; bus.uio_in = 8'h00; rst_n = 1'b1;
        m_acc = 0; m_z = 0; m_c = 0; m_n = 0; m_disp = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;

        step("reset0", 8'h10, 8'hAA, 1'b1, 1'b1);
        step("reset1", 8'h10, 8'hAA, 1'b1, 1'b1);
        check("reset_out", int'(bus.uo_out), 0);
        run("nop_flags", 8'h01, 0);
        check("reset_flags", int'(bus.uo_out), 0);
        run("nop_acc", 8'h00, 0);

        run("ldi", 8'h10, 8'h3C);
        check("ldi_3c", int'(bus.uo_out), 8'h3C);
        run("mov_r2", 8'h28, 0);
        run("ldi5", 8'h10, 8'h05);
        run("ldr_r2", 8'h32, 0);
        check("ldr_3c", int'(bus.uo_out), 8'h3C);

        run("ldi_ff", 8'h10, 8'hFF);
        run("mov_r1", 8'h24, 0);
        run("ldi_01", 8'h10, 8'h01);
        run("add_wrap", 8'h41, 0);
        check("add_zero", int'(bus.uo_out), 8'h00);
        run("flags_zc", 8'h01, 0);
        check("flags_03", int'(bus.uo_out), 8'h03);
        run("disp_acc", 8'h00, 0);

        run("ldi_00", 8'h10, 8'h00);
        run("mov_r0", 8'h20, 0);
        run("inc", 8'hC0, 0);
        run("sub_r0", 8'h50, 0);
        run("dec1", 8'hD0, 0);
        run("dec2", 8'hD0, 0);
        check("dec_ff", int'(bus.uo_out), 8'hFF);
        run("flags_nc", 8'h01, 0);
        check("flags_06", int'(bus.uo_out), 8'h06);
        run("disp_acc2", 8'h00, 0);

        for (int i = 0; i < 3; i++) step("ena_off", 8'h10, 8'h77, 1'b0, 1'b0);
        check("ena_hold", int'(bus.uo_out), 8'hFF);
        run("ena_on", 8'h10, 8'h77);
        check("ena_77", int'(bus.uo_out), 8'h77);

        run("ldi_81", 8'h10, 8'h81);
        run("shl", 8'hA0, 0);
        check("shl_02", int'(bus.uo_out), 8'h02);
        run("shr", 8'hB0, 0);
        run("ldi_10", 8'h10, 8'h10);
        run("mov_r3", 8'h2C, 0);
        run("op_f", 8'hF3, 0);
`ifdef TT_PROCESSOR_MUL_EN
        check("mul_acc", int'(bus.uo_out), 8'h00);
`else
        check("cmp_acc", int'(bus.uo_out), 8'h10);
`endif
        run("f_flags", 8'h01, 0);
        check("f_flags_z", int'(bus.uo_out) % 2, 1);
        run("disp_acc3", 8'h00, 0);

        for (int i = 0; i < 3000; i++) begin
            int ui, imm;
            bit en, rs;
            ui  = int'($urandom_range(0, 255));
            imm = int'($urandom_range(0, 255));
            en  = ($urandom_range(0, 7) != 0);
            rs  = ($urandom_range(0, 99) == 0);
            step("rand", ui, imm, en, rs);
            if (i % 500 == 0) begin
                check("uio_out", int'(bus.uio_out), 0);
                check("uio_oe", int'(bus.uio_oe), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/tt_processor.md
Name: tt_processor

Overview:
- 8-bit accumulator processor and the Tiny Tapeout top-level user block.
- Executes one instruction per clock, taken from the dedicated inputs ui_in.
- An 8-bit immediate/data operand comes from the bidirectional inputs uio_in, used as inputs only.
- The result (accumulator or flags) is presented on uo_out.

Parameters:
- none (all widths fixed at 8 bits; register file fixed at 4 entries)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  reset: synchronous, active-high (asserted when 1); name kept per codebase port naming
- ena  input  1  design enable; when 0 all state holds
- ui_in  input  8  instruction: [7:4] opcode, [3:2] rd, [1:0] rs
- uio_in  input  8  immediate operand IMM for LDI/ADDI
- uo_out  output  8  display: ACC, or {5'b0,N,C,Z} when disp_sel=1
- uio_out  output  8  constant 8'h00
- uio_oe  output  8  constant 8'h00 (all uio pins are inputs)

Behaviour:
- State: ACC[7:0], R0..R3[7:0], flags Z/C/N, disp_sel.
- Reset (rst_n=1 at clock edge): all state cleared to 0, so uo_out=0x00 the cycle after. Reset has priority over ena and any instruction.
- ena=0: no state changes; outputs hold.
- Latency: instruction sampled at the edge; new ACC/flags/R visible on uo_out immediately after that edge (one instruction per cycle, no stalls).
- Opcodes; all arithmetic is 8-bit, wraps modulo 256:
  - 0 NOP: no state change except disp_sel <= ui_in[0].
  - 1 LDI: ACC <= IMM.
  - 2 MOV: R[rd] <= ACC; flags unchanged.
  - 3 LDR: ACC <= R[rs].
  - 4 ADD: ACC <= ACC+R[rs]; C=carry-out.
  - 5 SUB: ACC <= ACC-R[rs]; C=borrow (1 when ACC<R[rs] unsigned).
  - 6 AND, 7 OR, 8 XOR: ACC <= ACC op R[rs]; C<=0.
  - 9 NOT: ACC <= ~ACC; C<=0.
  - A SHL: ACC <= ACC<<1; C=old ACC[7].
  - B SHR (logical): ACC <= ACC>>1; C=old ACC[0].
  - C INC: C=1 on 0xFF->0x00.
  - D DEC: C=1 on 0x00->0xFF.
  - E ADDI: ACC <= ACC+IMM; C=carry-out.
  - F CMP: compute ACC-R[rs]; update flags as SUB; ACC unchanged.
- Flag rules:
  - Every ACC-writing op and CMP: Z=(result==0), N=result[7].
  - LDI/LDR leave C unchanged.
  - NOP/MOV leave all flags unchanged.
- Register operand reads see values from before the edge. MOV to rd with LDR from the same index in a later cycle returns the new value.
- Boundaries: ADD 0xFF+0x01 -> 0x00, Z=1, C=1. SUB 0x00-0x01 -> 0xFF, C=1, N=1.

Optional Feature:
- Macro: TT_PROCESSOR_MUL_EN.
- Defined: opcode F is MUL: ACC <= low byte of ACC*R[rs]; C = OR of the high product byte; Z/N from the low byte.
- Undefined: opcode F is CMP as above; no multiplier synthesized.

Test Plan:
- Reset: hold rst_n=1 two cycles with ui_in=0x1_ (LDI), uio_in=0xAA -> uo_out=0x00. Release; NOP with ui_in[0]=1 -> uo_out=0x00 (flags clear).
- LDI 0x3C (ui_in=0x10, uio_in=0x3C) -> uo_out=0x3C. MOV R2 (0x28) -> ACC still 0x3C. LDI 0x05; LDR R2 (0x32) -> uo_out=0x3C.
- Carry/wrap: LDI 0xFF, MOV R1, LDI 0x01, ADD R1 (0x41) -> uo_out=0x00. NOP 0x01 -> uo_out=0x03 (Z=1, C=1).
- Borrow: LDI 0x00, MOV R0, INC (0xC0) -> 0x01, SUB R0 -> 0x01 C=0, DEC twice -> 0xFF. Display flags -> 0x06 (N=1, C=1).
- ena=0 while ui_in=LDI 0x77 for 3 cycles -> uo_out unchanged. Reassert ena -> 0x77.
- Shifts/CMP: LDI 0x81, SHL -> 0x02 C=1, SHR -> 0x01 C=0. LDI 0x10, R3=0x10, CMP R3 (0xF3) -> ACC 0x10, Z=1. With TT_PROCESSOR_MUL_EN: 0x10*0x10 -> 0x00, C=1, Z=1.
